bcd_operand_loader: RTL and testbench

//   Upstream stage of the two-digit BCD adder/display path. Captures BCD operand A, then

---
 rtl/bcd_operand_loader_pkg.sv | 15 +
 rtl/bcd_operand_loader_key_debounce.sv | 52 +++++
 rtl/bcd_operand_loader.sv | 90 +++++++++
 tb/tb_bcd_operand_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_operand_loader_pkg.sv
// Shared constants for the two-digit BCD operand loader and adder path.
// State encodings are also driven onto the State LEDs.
package bcd_operand_loader_pkg;

    localparam logic [1:0] S_A = 2'b00;
    localparam logic [1:0] S_B = 2'b01;
    localparam logic [1:0] S_V = 2'b10;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_operand_loader_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter and a
// one-cycle pulse on each accepted press (stable high-to-low transition).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = r_sync2 != r_stable;
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            // only a settled 1->0 change is an event; release is silent
            r_press <= w_done && r_stable;
            if (w_done) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/bcd_operand_loader.sv
// Captures BCD operand A, then B plus carry-in, on debounced presses and
// holds them under a valid/ready handshake to the adder stage.
module bcd_operand_loader
    import bcd_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load_n,
    input  logic [3:0] Digit,
    input  logic       Cin_in,
    input  logic       Ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Cin,
    output logic       Valid,
    output logic       Err,
    output logic [1:0] State
);

    logic       w_press;
    logic [1:0] r_state;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_cin;
    logic       r_err;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .Clock(Clock),
        .Reset(Reset),
        .key_n(Load_n),
        .press(w_press)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_A;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_cin   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_press) begin
                        if (is_bcd(Digit)) begin
                            r_a     <= Digit;
                            r_err   <= 1'b0;
                            r_state <= S_B;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (w_press) begin
                        if (is_bcd(Digit)) begin
                            r_b     <= Digit;
                            r_cin   <= Cin_in;
                            r_err   <= 1'b0;
                            r_state <= S_V;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                // presses are dropped while the adder owns the operands
                S_V: begin
                    if (Ready) begin
                        r_state <= S_A;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign Cin   = r_cin;
    assign Valid = (r_state == S_V);
    assign Err   = r_err;
    assign State = r_state;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed self-checking bench for bcd_operand_loader with a short
// debounce window (4 cycles) so presses settle in a handful of clocks.
module tb_bcd_operand_loader;

    logic       Clock;
    logic       Reset;
    logic       Load_n;
    logic [3:0] Digit;
    logic       Cin_in;
    logic       Ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       Valid;
    logic       Err;
    logic [1:0] State;

    int n_cmp;
    int n_err;
    int cnt_max;

    bcd_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Load_n(Load_n),
        .Digit (Digit),
        .Cin_in(Cin_in),
        .Ready (Ready),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Valid (Valid),
        .Err   (Err),
        .State (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (int'(dut.u_debounce.r_cnt) > cnt_max)
            cnt_max = int'(dut.u_debounce.r_cnt);
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input logic c);
        Digit  = d;
        Cin_in = c;
        Load_n = 1'b0;
        cyc(8);
        Load_n = 1'b1;
        cyc(8);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cnt_max = 0;
        Reset   = 1'b1;
        Load_n  = 1'b1;
        Digit   = 4'd0;
        Cin_in  = 1'b0;
        Ready   = 1'b0;
        cyc(3);
        chk("rst_A", 8'(A), 8'h0);
        chk("rst_B", 8'(B), 8'h0);
        chk("rst_Cin", 8'(Cin), 8'h0);
        chk("rst_Valid", 8'(Valid), 8'h0);
        chk("rst_Err", 8'(Err), 8'h0);
        chk("rst_State", 8'(State), 8'h0);
        Reset = 1'b0;
        cyc(3);

        // latency: Load_n falls just after edge t
        Digit  = 4'd7;
        Load_n = 1'b0;
        cyc(6);
        chk("lat_t6_State", 8'(State), 8'h0);
        chk("lat_t6_A", 8'(A), 8'h0);
        cyc(1);
        chk("lat_t7_State", 8'(State), 8'h1);
        chk("lat_t7_A", 8'(A), 8'h7);
        cyc(12);
        chk("hold_no_repeat", 8'(State), 8'h1);
        Load_n = 1'b1;
        cyc(8);
        chk("release_no_evt", 8'(State), 8'h1);

        press(4'd5, 1'b1);
        chk("norm_A", 8'(A), 8'h7);
        chk("norm_B", 8'(B), 8'h5);
        chk("norm_Cin", 8'(Cin), 8'h1);
        chk("norm_Valid", 8'(Valid), 8'h1);
        chk("norm_State", 8'(State), 8'h2);

        press(4'd3, 1'b0);
        chk("sv_press_A", 8'(A), 8'h7);
        chk("sv_press_B", 8'(B), 8'h5);
        chk("sv_press_Valid", 8'(Valid), 8'h1);
        chk("sv_press_Err", 8'(Err), 8'h0);

        Ready = 1'b1;
        cyc(1);
        Ready = 1'b0;
        chk("hs_State", 8'(State), 8'h0);
        chk("hs_Valid", 8'(Valid), 8'h0);
        chk("hs_A_held", 8'(A), 8'h7);
        chk("hs_B_held", 8'(B), 8'h5);

        // bounce: 3 low, 1 high, 3 low
        Digit  = 4'd2;
        Load_n = 1'b0;
        cyc(3);
        Load_n = 1'b1;
        cyc(1);
        Load_n = 1'b0;
        cyc(3);
        Load_n = 1'b1;
        cyc(8);
        chk("bounce_State", 8'(State), 8'h0);
        chk("bounce_A", 8'(A), 8'h7);

        Load_n = 1'b0;
        cyc(6);
        Load_n = 1'b1;
        cyc(8);
        chk("six_low_State", 8'(State), 8'h1);
        chk("six_low_A", 8'(A), 8'h2);

        press(4'hC, 1'b1);
        chk("sb_bad_Err", 8'(Err), 8'h1);
        chk("sb_bad_State", 8'(State), 8'h1);
        press(4'd4, 1'b0);
        chk("sb_ok_B", 8'(B), 8'h4);
        chk("sb_ok_Cin", 8'(Cin), 8'h0);
        chk("sb_ok_Err", 8'(Err), 8'h0);
        Ready = 1'b1;
        cyc(1);
        Ready = 1'b0;

        press(4'hC, 1'b0);
        chk("sa_bad_Err", 8'(Err), 8'h1);
        chk("sa_bad_State", 8'(State), 8'h0);
        chk("sa_bad_A", 8'(A), 8'h2);
        press(4'd9, 1'b0);
        chk("sa_nine_A", 8'(A), 8'h9);
        chk("sa_nine_Err", 8'(Err), 8'h0);
        chk("sa_nine_State", 8'(State), 8'h1);

        press(4'hA, 1'b0);
        chk("sb_ten_Err", 8'(Err), 8'h1);
        chk("sb_ten_State", 8'(State), 8'h1);

        // asynchronous reset while a press is being debounced in S_B
        Digit  = 4'd1;
        Load_n = 1'b0;
        cyc(3);
        Reset = 1'b1;
        #1;
        chk("arst_A", 8'(A), 8'h0);
        chk("arst_Err", 8'(Err), 8'h0);
        chk("arst_State", 8'(State), 8'h0);
        Load_n = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(3);
        press(4'd6, 1'b0);
        chk("post_rst_A", 8'(A), 8'h6);
        chk("post_rst_B", 8'(B), 8'h0);
        chk("post_rst_State", 8'(State), 8'h1);

        press(4'd8, 1'b1);
        chk("sv2_State", 8'(State), 8'h2);

        // press pulse lands on the same edge as Ready
        Digit  = 4'd1;
        Load_n = 1'b0;
        cyc(6);
        Ready = 1'b1;
        cyc(1);
        Ready = 1'b0;
        chk("coinc_State", 8'(State), 8'h0);
        Load_n = 1'b1;
        cyc(8);
        chk("coinc_State_late", 8'(State), 8'h0);
        chk("coinc_A", 8'(A), 8'h6);
        chk("coinc_B", 8'(B), 8'h8);

        Ready = 1'b1;
        cyc(2);
        Ready = 1'b0;
        chk("ready_in_sa", 8'(State), 8'h0);

        chk("cnt_max", 8'(cnt_max), 8'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
